chan_mailbox: RTL



---
 rtl/chan_mailbox_pkg.sv | 20 ++
 rtl/chan_mailbox_fifo.sv | 56 +++++
 rtl/chan_mailbox.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_mailbox_pkg.sv
// Shared definitions for the channel mailbox: inter-CPU message codes and
// the controller state encoding.
package chan_mailbox_pkg;

  // Inter-CPU message field width and the codes the mailbox reacts to.
  localparam int CPU_MSG_SIZE = 8;
  localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_SET       = 8'h31;
  localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_GET       = 8'h32;
  localparam logic [CPU_MSG_SIZE-1:0] CPU_R_THREAD_ADDRESS = 8'h33;

  // Mailbox controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_ACT     = 3'd2,
    ST_REPLY_D = 3'd3,
    ST_REPLY_T = 3'd4
  } mb_state_e;

endpackage

// File: rtl/chan_mailbox_fifo.sv
// Two-entry message buffer in front of the mailbox controller. A push into
// a full buffer is dropped and flagged on ovf for that cycle.
module chan_mailbox_fifo #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         ovf
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic         full_s;
  logic         do_push_s;
  logic         do_pop_s;

  // Occupancy decode and accept/drop decisions for this cycle.
  always_comb begin
    full_s    = (cnt_r == 2'd2);
    empty     = (cnt_r == 2'd0);
    do_push_s = push && !full_s;
    do_pop_s  = pop && !empty;
    ovf       = push && full_s;
    rdata     = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/chan_mailbox.sv
// Channel mailbox: stores posted channel words, parks readers that arrive
// before the word, and answers each completed transfer with a CHAN_SET
// broadcast followed (when known) by the writer's THREAD_ADDRESS.
module chan_mailbox
  import chan_mailbox_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MSG_W  = CPU_MSG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              msg_strb_i,
  input  logic [MSG_W-1:0]  msg_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              msg_valid_o,
  output logic [MSG_W-1:0]  msg_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_ovf_o,
  output logic              err_full_o,
  output logic              err_ovr_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int FW    = MSG_W + ADDR_W + DATA_W;
  localparam logic [MSG_W-1:0] M_SET = MSG_W'(CPU_R_CHAN_SET);
  localparam logic [MSG_W-1:0] M_GET = MSG_W'(CPU_R_CHAN_GET);
  localparam logic [MSG_W-1:0] M_TA  = MSG_W'(CPU_R_THREAD_ADDRESS);

  // Slot table.
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  full_r;
  logic [DEPTH-1:0]  pend_r;
  logic [DEPTH-1:0]  wthr_v_r;
  logic [ADDR_W-1:0] tag_r  [DEPTH];
  logic [DATA_W-1:0] word_r [DEPTH];
  logic [ADDR_W-1:0] wthr_r [DEPTH];

  // Controller state and the message being worked on.
  mb_state_e         state_r;
  logic [MSG_W-1:0]  cur_msg_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [DATA_W-1:0] cur_data_r;
  logic              hit_r;
  logic [IDX_W-1:0]  idx_r;
  logic              free_v_r;
  logic [IDX_W-1:0]  free_idx_r;
  logic [IDX_W-1:0]  last_set_r;
  logic [IDX_W-1:0]  rep_idx_r;

  // Registered broadcast and error outputs.
  logic              msg_valid_r;
  logic [MSG_W-1:0]  msg_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              err_ovf_r;
  logic              err_full_r;
  logic              err_ovr_r;

  // Combinational helpers.
  logic              push_s;
  logic              pop_s;
  logic [FW-1:0]     fifo_rdata_s;
  logic              fifo_empty_s;
  logic              fifo_ovf_s;
  logic              hit_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic              free_v_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic [IDX_W-1:0]  tgt_s;

  // Only channel traffic enters the buffer; the controller pops only when idle.
  always_comb begin
    push_s = clk_oe && msg_strb_i &&
             ((msg_i == M_SET) || (msg_i == M_GET) || (msg_i == M_TA));
    pop_s  = clk_oe && (state_r == ST_IDLE) && !fifo_empty_s;
  end

  chan_mailbox_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({msg_i, addr_i, data_i}),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .ovf   (fifo_ovf_s)
  );

  // Tag compare plus lowest-index priority encode for hit and free slot;
  // scanning downward lets the lowest index win.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {IDX_W{1'b0}};
    free_v_s   = 1'b0;
    free_idx_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx_s  = (valid_r[i] && (tag_r[i] == cur_addr_r)) ? IDX_W'(i) : hit_idx_s;
      hit_s      = hit_s | (valid_r[i] && (tag_r[i] == cur_addr_r));
      free_idx_s = (!valid_r[i]) ? IDX_W'(i) : free_idx_s;
      free_v_s   = free_v_s | !valid_r[i];
    end
    tgt_s = hit_r ? idx_r : free_idx_r;
  end

  // Controller: pop, lookup, act on the table, then drive the reply broadcasts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_msg_r   <= {MSG_W{1'b0}};
      cur_addr_r  <= {ADDR_W{1'b0}};
      cur_data_r  <= {DATA_W{1'b0}};
      hit_r       <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      free_v_r    <= 1'b0;
      free_idx_r  <= {IDX_W{1'b0}};
      last_set_r  <= {IDX_W{1'b0}};
      rep_idx_r   <= {IDX_W{1'b0}};
      valid_r     <= {DEPTH{1'b0}};
      full_r      <= {DEPTH{1'b0}};
      pend_r      <= {DEPTH{1'b0}};
      wthr_v_r    <= {DEPTH{1'b0}};
      msg_valid_r <= 1'b0;
      msg_r       <= {MSG_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      err_ovf_r   <= 1'b0;
      err_full_r  <= 1'b0;
      err_ovr_r   <= 1'b0;
    end else if (!clk_oe) begin
      msg_valid_r <= 1'b0;
      msg_r       <= {MSG_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
    end else begin
      // Broadcast is a one-cycle pulse unless a state below re-drives it.
      msg_valid_r <= 1'b0;
      msg_r       <= {MSG_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      if (fifo_ovf_s) begin
        err_ovf_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            cur_msg_r  <= fifo_rdata_s[FW-1 -: MSG_W];
            cur_addr_r <= fifo_rdata_s[DATA_W +: ADDR_W];
            cur_data_r <= fifo_rdata_s[DATA_W-1:0];
            state_r    <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          hit_r      <= hit_s;
          idx_r      <= hit_idx_s;
          free_v_r   <= free_v_s;
          free_idx_r <= free_idx_s;
          state_r    <= ST_ACT;
        end

        ST_ACT: begin
          state_r <= ST_IDLE;
          case (cur_msg_r)
            M_SET: begin
              if (!hit_r && !free_v_r) begin
                err_full_r <= 1'b1;
              end else begin
                if (hit_r && full_r[idx_r]) begin
                  err_ovr_r <= 1'b1;
                end
                word_r[tgt_s]   <= cur_data_r;
                tag_r[tgt_s]    <= cur_addr_r;
                full_r[tgt_s]   <= 1'b1;
                valid_r[tgt_s]  <= 1'b1;
                wthr_v_r[tgt_s] <= 1'b0;
                last_set_r      <= tgt_s;
                if (hit_r && pend_r[idx_r]) begin
                  // A reader is parked on this channel: answer it now.
                  rep_idx_r   <= tgt_s;
                  msg_valid_r <= 1'b1;
                  msg_r       <= M_SET;
                  addr_r      <= cur_addr_r;
                  data_r      <= cur_data_r;
                  state_r     <= ST_REPLY_D;
                end else begin
                  pend_r[tgt_s] <= 1'b0;
                end
              end
            end

            M_GET: begin
              if (hit_r) begin
                if (full_r[idx_r]) begin
                  rep_idx_r   <= idx_r;
                  msg_valid_r <= 1'b1;
                  msg_r       <= M_SET;
                  addr_r      <= tag_r[idx_r];
                  data_r      <= word_r[idx_r];
                  state_r     <= ST_REPLY_D;
                end else begin
                  pend_r[idx_r] <= 1'b1;
                end
              end else if (free_v_r) begin
                valid_r[free_idx_r]  <= 1'b1;
                tag_r[free_idx_r]    <= cur_addr_r;
                full_r[free_idx_r]   <= 1'b0;
                pend_r[free_idx_r]   <= 1'b1;
                wthr_v_r[free_idx_r] <= 1'b0;
              end else begin
                err_full_r <= 1'b1;
              end
            end

            M_TA: begin
              // Only attach the thread to a word that is still waiting for its reader.
              if (valid_r[last_set_r] && full_r[last_set_r]) begin
                wthr_r[last_set_r]   <= cur_addr_r;
                wthr_v_r[last_set_r] <= 1'b1;
              end
            end

            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end

        ST_REPLY_D: begin
          full_r[rep_idx_r] <= 1'b0;
          pend_r[rep_idx_r] <= 1'b0;
          if (wthr_v_r[rep_idx_r]) begin
            msg_valid_r <= 1'b1;
            msg_r       <= M_TA;
            addr_r      <= wthr_r[rep_idx_r];
            data_r      <= DATA_W'(wthr_r[rep_idx_r]);
            state_r     <= ST_REPLY_T;
          end else begin
            valid_r[rep_idx_r] <= 1'b0;
            state_r            <= ST_IDLE;
          end
        end

        ST_REPLY_T: begin
          valid_r[rep_idx_r]  <= 1'b0;
          wthr_v_r[rep_idx_r] <= 1'b0;
          state_r             <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign msg_valid_o = msg_valid_r;
  assign msg_o       = msg_r;
  assign addr_o      = addr_r;
  assign data_o      = data_r;
  assign err_ovf_o   = err_ovf_r;
  assign err_full_o  = err_full_r;
  assign err_ovr_o   = err_ovr_r;
  assign busy_o      = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule
